// File: rtl/sd_sector_reader_pkg.sv
// Purpose: shared encodings for the SD single-block read sequencer.
// Contents: FSM states, CPU register indices, error codes, SD command bytes.
// Helpers: CMD17 frame byte selector and a saturating retry-counter increment.
package sd_sector_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_R1,
        ST_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_TAIL,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_R1    = 2'd1,
        ERR_TOKEN = 2'd2,
        ERR_ABORT = 2'd3
    } err_t;

    localparam logic [3:0] REG_SEC_LO = 4'd0;
    localparam logic [3:0] REG_SEC_HI = 4'd1;
    localparam logic [3:0] REG_CTRL   = 4'd2;
    localparam logic [3:0] REG_STATUS = 4'd3;
    localparam logic [3:0] REG_R1     = 4'd4;

    localparam logic [7:0] CMD17      = 8'h51;
    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    localparam logic [7:0] DUMMY_CRC  = 8'h01;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;

    // Byte idx of the 6-byte CMD17 frame: opcode, 4 argument bytes MSB first, CRC.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] arg);
        case (idx)
            3'd0:    cmd_byte = CMD17;
            3'd1:    cmd_byte = arg[31:24];
            3'd2:    cmd_byte = arg[23:16];
            3'd3:    cmd_byte = arg[15:8];
            3'd4:    cmd_byte = arg[7:0];
            default: cmd_byte = DUMMY_CRC;
        endcase
    endfunction

    function automatic logic [12:0] sat_inc(input logic [12:0] cnt);
        sat_inc = (cnt == 13'h1FFF) ? cnt : cnt + 13'd1;
    endfunction

endpackage

// File: rtl/sd_sector_reader_regs.sv
// Purpose: CPU-visible register file and registered read mux of the SD sector reader.
// Ports: J1 bus (d_in/cs/addr/rd/wr/d_out), status inputs from the sequencer,
//        sector value and one-cycle start/abort write strobes towards the sequencer.
module sd_sector_reader_regs
    import sd_sector_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic        busy,
    input  logic        done,
    input  err_t        err,
    input  logic [7:0]  last_r1,
    output logic [15:0] d_out,
    output logic [31:0] sector,
    output logic        start_req,
    output logic        abort_req
);

    logic        wr_en;
    logic [15:0] rd_mux;

    assign wr_en     = cs & wr;
    // Combinational strobes so the sequencer reacts on the same edge as the write.
    assign start_req = wr_en && (addr == REG_CTRL) && d_in[0];
    assign abort_req = wr_en && (addr == REG_CTRL) && d_in[1];

    always_comb begin
        rd_mux = 16'h0000;
        case (addr)
            REG_SEC_LO: rd_mux = sector[15:0];
            REG_SEC_HI: rd_mux = sector[31:16];
            REG_STATUS: rd_mux = {12'h000, err, done, busy};
            REG_R1:     rd_mux = {8'h00, last_r1};
            default:    rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sector <= 32'h0000_0000;
            d_out  <= 16'h0000;
        end else begin
            if (wr_en && addr == REG_SEC_LO) sector[15:0]  <= d_in;
            if (wr_en && addr == REG_SEC_HI) sector[31:16] <= d_in;
            if (cs && rd) d_out <= rd_mux;
        end
    end

endmodule

// File: rtl/sd_sector_reader.sv
// Purpose: autonomous CMD17 single-block read from microSD over an SPI byte engine into dpRAM.
// Ports: sys_clk_i/sys_rst_i, J1 register bus, SPI byte engine handshake (start/tx/rx/done),
//        SD chip select ss, dpRAM word write port (256 big-endian 16-bit words per sector).
module sd_sector_reader
    import sd_sector_reader_pkg::*;
#(
    parameter int R1_TRIES    = 8,
    parameter int TOKEN_TRIES = 4096,
    parameter int BYTE_ADDR   = 0
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic [7:0]  spi_rx,
    input  logic        spi_done,
    output logic        ss,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_dout
);

    state_t      state;
    err_t        err;
    logic        done;
    logic        abort_pend;
    logic [7:0]  last_r1;
    logic [31:0] sector;
    logic [31:0] arg;
    logic [9:0]  byte_cnt;
    logic [12:0] tries;
    logic [7:0]  data_hi;
    logic        start_req;
    logic        abort_req;

    sd_sector_reader_regs u_regs (
        .clk       (sys_clk_i),
        .rst_n     (sys_rst_i),
        .d_in      (d_in),
        .cs        (cs),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .busy      (state != ST_IDLE),
        .done      (done),
        .err       (err),
        .last_r1   (last_r1),
        .d_out     (d_out),
        .sector    (sector),
        .start_req (start_req),
        .abort_req (abort_req)
    );

    // Every busy state has exactly one byte outstanding: a new spi_start is only
    // issued on the edge that consumes spi_done, so starts never overlap.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state      <= ST_IDLE;
            err        <= ERR_OK;
            done       <= 1'b0;
            abort_pend <= 1'b0;
            last_r1    <= 8'h00;
            arg        <= 32'h0000_0000;
            byte_cnt   <= 10'd0;
            tries      <= 13'd0;
            data_hi    <= 8'h00;
            spi_start  <= 1'b0;
            spi_tx     <= FILL_BYTE;
            ss         <= 1'b1;
            ram_we     <= 1'b0;
            ram_addr   <= 8'h00;
            ram_dout   <= 16'h0000;
        end else begin
            spi_start <= 1'b0;
            ram_we    <= 1'b0;
            // Address advances after the word strobe; parks at 255 rather than wrapping.
            if (ram_we && ram_addr != 8'hFF) ram_addr <= ram_addr + 8'd1;
            if (abort_req && state != ST_IDLE) abort_pend <= 1'b1;

            if (state == ST_IDLE) begin
                if (start_req) begin
                    state      <= ST_CMD;
                    ss         <= 1'b0;
                    spi_tx     <= CMD17;
                    spi_start  <= 1'b1;
                    byte_cnt   <= 10'd0;
                    tries      <= 13'd0;
                    arg        <= (BYTE_ADDR != 0) ? {sector[22:0], 9'd0} : sector;
                    ram_addr   <= 8'h00;
                    done       <= 1'b0;
                    err        <= ERR_OK;
                    abort_pend <= 1'b0;
                end
            end else if (spi_done) begin
                if (abort_pend && state != ST_ERR) begin
                    abort_pend <= 1'b0;
                    state      <= ST_ERR;
                    err        <= ERR_ABORT;
                    ss         <= 1'b1;
                    spi_tx     <= FILL_BYTE;
                    spi_start  <= 1'b1;
                end else begin
                    case (state)
                        ST_CMD: begin
                            spi_start <= 1'b1;
                            if (byte_cnt == 10'd5) begin
                                state  <= ST_R1;
                                tries  <= 13'd0;
                                spi_tx <= FILL_BYTE;
                            end else begin
                                byte_cnt <= byte_cnt + 10'd1;
                                spi_tx   <= cmd_byte(byte_cnt[2:0] + 3'd1, arg);
                            end
                        end
                        ST_R1: begin
                            last_r1   <= spi_rx;
                            tries     <= sat_inc(tries);
                            spi_start <= 1'b1;
                            if (spi_rx == 8'h00) begin
                                state <= ST_TOKEN;
                                tries <= 13'd0;
                            end else if (!spi_rx[7] || sat_inc(tries) == 13'(R1_TRIES)) begin
                                state <= ST_ERR;
                                err   <= ERR_R1;
                                ss    <= 1'b1;
                            end
                        end
                        ST_TOKEN: begin
                            tries     <= sat_inc(tries);
                            spi_start <= 1'b1;
                            if (spi_rx == DATA_TOKEN) begin
                                state    <= ST_DATA;
                                byte_cnt <= 10'd0;
                            end else if (spi_rx != FILL_BYTE || sat_inc(tries) == 13'(TOKEN_TRIES)) begin
                                state <= ST_ERR;
                                err   <= ERR_TOKEN;
                                ss    <= 1'b1;
                            end
                        end
                        ST_DATA: begin
                            spi_start <= 1'b1;
                            if (!byte_cnt[0]) begin
                                data_hi <= spi_rx;
                            end else begin
                                ram_dout <= {data_hi, spi_rx};
                                ram_we   <= 1'b1;
                            end
                            if (byte_cnt == 10'd511) begin
                                state    <= ST_CRC;
                                byte_cnt <= 10'd0;
                            end else begin
                                byte_cnt <= byte_cnt + 10'd1;
                            end
                        end
                        ST_CRC: begin
                            spi_start <= 1'b1;
                            if (byte_cnt[0]) begin
                                state <= ST_TAIL;
                                ss    <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 10'd1;
                            end
                        end
                        ST_TAIL, ST_ERR: begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_reader.sv
`timescale 1ns/1ps
module tb_sd_sector_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] d_in = 16'h0;
    logic        cs = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        sel_b = 1'b0;
    logic [7:0]  spi_rx = 8'hFF;
    logic        done_raw = 1'b0;

    logic        cs_a, cs_b, done_a, done_b;
    logic [15:0] d_out, d_out_b, ram_dout, ram_dout_b;
    logic        spi_start, spi_start_b, ss, ss_b, ram_we, ram_we_b;
    logic [7:0]  spi_tx, spi_tx_b, ram_addr, ram_addr_b;

    assign cs_a   = cs & ~sel_b;
    assign cs_b   = cs & sel_b;
    assign done_a = done_raw & ~sel_b;
    assign done_b = done_raw & sel_b;

    sd_sector_reader u_dut (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .d_in(d_in), .cs(cs_a), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out), .spi_start(spi_start), .spi_tx(spi_tx),
        .spi_rx(spi_rx), .spi_done(done_a), .ss(ss), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_dout(ram_dout)
    );

    sd_sector_reader #(.BYTE_ADDR(1)) u_dut_ba (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .d_in(d_in), .cs(cs_b), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out_b), .spi_start(spi_start_b), .spi_tx(spi_tx_b),
        .spi_rx(spi_rx), .spi_done(done_b), .ss(ss_b), .ram_we(ram_we_b),
        .ram_addr(ram_addr_b), .ram_dout(ram_dout_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SD card / SPI byte engine model ----------------
    int         r1_at = 2;       // R1 response arrives on this poll (1-based)
    logic [7:0] r1_val = 8'h00;
    int         tok_ff = 3;      // 0xFF bytes before the token
    logic [7:0] tok_val = 8'hFE;
    int         xfer = 0;
    int         data_idx = -1;
    int         wait_cnt = 0;
    int         viol = 0;
    logic [7:0] pend_rx;
    logic [7:0] mosi_q[$];

    function automatic logic [7:0] rx_for(input int idx);
        int r, t, d;
        if (idx < 6) return 8'hFF;
        r = idx - 6;
        if (r < r1_at - 1) return 8'hFF;
        if (r == r1_at - 1) return r1_val;
        t = r - r1_at;
        if (t < tok_ff) return 8'hFF;
        if (t == tok_ff) return tok_val;
        d = t - tok_ff - 1;
        if (d < 512) return 8'(d);
        return 8'hFF;
    endfunction

    always @(negedge clk) begin
        done_raw = 1'b0;
        if (!rst_n) begin
            wait_cnt = 0;
        end else begin
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    spi_rx   = pend_rx;
                    done_raw = 1'b1;
                end
            end
            if (sel_b ? spi_start_b : spi_start) begin
                if (wait_cnt > 0) viol++;
                mosi_q.push_back(sel_b ? spi_tx_b : spi_tx);
                pend_rx  = rx_for(xfer);
                data_idx = xfer - 6 - r1_at - tok_ff - 1;
                if (data_idx < 0 || data_idx > 511) data_idx = -1;
                xfer++;
                wait_cnt = 3;
            end
        end
    end

    // ---------------- RAM write scoreboard ----------------
    logic [23:0] exp_q[$];
    int          ram_cnt = 0;

    always @(negedge clk) begin
        logic [23:0] e;
        if (rst_n && ram_we) begin
            ram_cnt++;
            if (exp_q.size() == 0) begin
                check("ram_unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("ram_addr", 32'(ram_addr), 32'(e[23:16]));
                check("ram_data", 32'(ram_dout), 32'(e[15:0]));
            end
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
        @(posedge clk); #1;
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
        v = sel_b ? d_out_b : d_out;
    endtask

    task automatic wait_idle(input string tag);
        logic [15:0] s;
        int n;
        s = 16'h0001;
        n = 0;
        while (s[0] && n < 20000) begin
            rd_reg(4'd3, s);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(s[0]), 32'd0);
    endtask

    task automatic arm(input int r1a, input logic [7:0] r1v, input int tff, input logic [7:0] tv);
        r1_at = r1a; r1_val = r1v; tok_ff = tff; tok_val = tv;
        xfer = 0; data_idx = -1; ram_cnt = 0;
        mosi_q.delete();
        exp_q.delete();
    endtask

    task automatic push_words(input int count);
        for (int k = 0; k < count; k++)
            exp_q.push_back({8'(k), 8'(2 * k), 8'(2 * k + 1)});
    endtask

    logic [15:0] v;
    int          n;
    int          n51;
    logic [7:0]  exp_cmd[6];

    initial begin
        // ---- reset state ----
        #12;
        check("rst_d_out", 32'(d_out), 32'h0);
        check("rst_spi_start", 32'(spi_start), 32'h0);
        check("rst_spi_tx", 32'(spi_tx), 32'hFF);
        check("rst_ss", 32'(ss), 32'h1);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_dout", 32'(ram_dout), 32'h0);
        rst_n = 1'b1;
        rd_reg(4'd3, v);
        check("rst_status", 32'(v), 32'h0);
        rd_reg(4'd7, v);
        check("unmapped_read", 32'(v), 32'h0);

        // ---- happy path ----
        wr_reg(4'd0, 16'h1234);
        wr_reg(4'd1, 16'h0000);
        rd_reg(4'd0, v);
        check("sector_lo_readback", 32'(v), 32'h1234);
        arm(2, 8'h00, 3, 8'hFE);
        push_words(256);
        wr_reg(4'd2, 16'h0001);
        wait_idle("happy");
        exp_cmd = '{8'h51, 8'h00, 8'h00, 8'h12, 8'h34, 8'h01};
        for (int i = 0; i < 6; i++)
            check($sformatf("happy_cmd_byte%0d", i), 32'(mosi_q[i]), 32'(exp_cmd[i]));
        check("happy_xfers", 32'(xfer), 32'd527);
        check("happy_ram_writes", 32'(ram_cnt), 32'd256);
        check("happy_sb_left", 32'(exp_q.size()), 32'd0);
        rd_reg(4'd3, v);
        check("happy_status", 32'(v), 32'h0002);
        rd_reg(4'd4, v);
        check("happy_r1", 32'(v), 32'h0000);
        check("happy_ss", 32'(ss), 32'h1);

        // ---- R1 error response ----
        arm(2, 8'h05, 3, 8'hFE);
        wr_reg(4'd2, 16'h0001);
        wait_idle("r1err");
        rd_reg(4'd3, v);
        check("r1err_status", 32'(v), 32'h0006);
        rd_reg(4'd4, v);
        check("r1err_reg4", 32'(v), 32'h0005);
        check("r1err_ss", 32'(ss), 32'h1);
        check("r1err_ram_writes", 32'(ram_cnt), 32'd0);
        check("r1err_xfers", 32'(xfer), 32'd9);

        // ---- token timeout: exactly 4096 polls then the release byte ----
        arm(1, 8'h00, 1000000, 8'hFE);
        wr_reg(4'd2, 16'h0001);
        wait_idle("toktmo");
        rd_reg(4'd3, v);
        check("toktmo_status", 32'(v), 32'h000A);
        check("toktmo_xfers", 32'(xfer), 32'(6 + 1 + 4096 + 1));
        check("toktmo_ram_writes", 32'(ram_cnt), 32'd0);

        // ---- error token, plus a start written while busy ----
        arm(2, 8'h00, 3, 8'h0B);
        wr_reg(4'd2, 16'h0001);
        n = 0;
        while (xfer < 3 && n < 1000) begin @(posedge clk); #1; n++; end
        check("busy_start_reach", 32'(xfer >= 3), 32'd1);
        wr_reg(4'd2, 16'h0001);
        wait_idle("errtok");
        rd_reg(4'd3, v);
        check("errtok_status", 32'(v), 32'h000A);
        check("errtok_xfers", 32'(xfer), 32'd13);
        n51 = 0;
        foreach (mosi_q[i]) if (mosi_q[i] == 8'h51) n51++;
        check("busy_start_ignored", 32'(n51), 32'd1);

        // ---- abort during data byte 100 ----
        arm(2, 8'h00, 3, 8'hFE);
        push_words(50);
        wr_reg(4'd2, 16'h0001);
        n = 0;
        while (data_idx != 100 && n < 5000) begin @(posedge clk); #1; n++; end
        check("abort_reach_byte100", 32'(data_idx), 32'd100);
        wr_reg(4'd2, 16'h0002);
        wait_idle("abort");
        rd_reg(4'd3, v);
        check("abort_status", 32'(v), 32'h000E);
        check("abort_ss", 32'(ss), 32'h1);
        check("abort_ram_writes", 32'(ram_cnt), 32'd50);
        check("abort_xfers", 32'(xfer), 32'd114);

        // ---- byte addressing instance ----
        sel_b = 1'b1;
        wr_reg(4'd0, 16'h0001);
        wr_reg(4'd1, 16'h0000);
        arm(2, 8'h05, 3, 8'hFE);
        wr_reg(4'd2, 16'h0001);
        wait_idle("byteaddr");
        exp_cmd = '{8'h51, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++)
            check($sformatf("byteaddr_cmd_byte%0d", i), 32'(mosi_q[i]), 32'(exp_cmd[i]));
        rd_reg(4'd3, v);
        check("byteaddr_status", 32'(v), 32'h0006);
        sel_b = 1'b0;

        // ---- asynchronous reset mid-DATA ----
        rd_reg(4'd0, v);
        check("pre_reset_d_out", 32'(v), 32'h1234);
        arm(2, 8'h00, 3, 8'hFE);
        push_words(256);
        wr_reg(4'd2, 16'h0001);
        n = 0;
        while (data_idx < 200 && n < 5000) begin @(posedge clk); #1; n++; end
        check("rst_reach_data", 32'(data_idx >= 200), 32'd1);
        check("pre_reset_ss", 32'(ss), 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_ss", 32'(ss), 32'h1);
        check("arst_spi_start", 32'(spi_start), 32'h0);
        check("arst_spi_tx", 32'(spi_tx), 32'hFF);
        check("arst_ram_we", 32'(ram_we), 32'h0);
        check("arst_ram_addr", 32'(ram_addr), 32'h0);
        check("arst_ram_dout", 32'(ram_dout), 32'h0);
        check("arst_d_out", 32'(d_out), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        rd_reg(4'd3, v);
        check("post_reset_status", 32'(v), 32'h0);
        rd_reg(4'd0, v);
        check("post_reset_sector", 32'(v), 32'h0);

        check("spi_overlapping_starts", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
